// File: rtl/dx_pkg.sv
// Shared types and helpers for the decode-to-execute pipeline stage.
// The payload is carried as one packed vector ordered {ctrl, imm, rd1, rd0, pc}.
package dx_pkg;

    localparam int DX_DATA_WIDTH = 32;
    localparam int DX_CTRL_WIDTH = 16;

    typedef enum logic [1:0] {
        DX_EMPTY = 2'd0,
        DX_FULL  = 2'd1,
        DX_SKID  = 2'd2
    } dx_state_e;

    // Reference layout of the packed payload at the default widths.
    typedef struct packed {
        logic [DX_CTRL_WIDTH-1:0] ctrl;
        logic [DX_DATA_WIDTH-1:0] imm;
        logic [DX_DATA_WIDTH-1:0] rd1;
        logic [DX_DATA_WIDTH-1:0] rd0;
        logic [DX_DATA_WIDTH-1:0] pc;
    } dx_payload_t;

    function automatic int dx_payload_width(input int data_width, input int ctrl_width);
        return 4 * data_width + ctrl_width;
    endfunction

endpackage

// File: rtl/dx_pipeline_stage_entry.sv
// Width-parametrised load/hold register used for the main and skid entries.
// Clears only on asynchronous reset; otherwise holds until load_i.
module dx_skid_entry #(
    parameter int WIDTH = 144
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Entry storage: load new payload or hold it bit-exact.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/dx_pipeline_stage.sv
// Decode-to-execute stage with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module dx_pipeline_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter bit SKID_EN    = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rd0,
    input  logic [DATA_WIDTH-1:0] in_rd1,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_rd0,
    output logic [DATA_WIDTH-1:0] out_rd1,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    import dx_pkg::*;

    localparam int PW = dx_payload_width(DATA_WIDTH, CTRL_WIDTH);

    dx_state_e            state_q, state_d;
    logic [PW-1:0]        in_payload_s, main_d, main_q, skid_q;
    logic                 main_load_s, skid_load_s, accept_s, fire_s;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    assign in_payload_s = {in_ctrl, in_imm, in_rd1, in_rd0, in_pc};
    assign accept_s     = in_valid && in_ready;
    assign fire_s       = out_valid && out_ready;

    // Next-state and entry-load decode; flush overrides every transition and drops the input.
    always_comb begin
        state_d     = state_q;
        main_load_s = 1'b0;
        skid_load_s = 1'b0;
        main_d      = in_payload_s;
        if (flush) begin
            state_d = DX_EMPTY;
        end else begin
            case (state_q)
                DX_EMPTY: begin
                    if (accept_s) begin
                        state_d     = DX_FULL;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = DX_EMPTY;
                    end
                end
                DX_FULL: begin
                    if (fire_s && accept_s) begin
                        state_d     = DX_FULL;
                        main_load_s = 1'b1;
                    end else if (fire_s) begin
                        state_d = DX_EMPTY;
                    end else if (accept_s && SKID_EN) begin
                        state_d     = DX_SKID;
                        skid_load_s = 1'b1;
                    end else begin
                        state_d = DX_FULL;
                    end
                end
                DX_SKID: begin
                    if (fire_s) begin
                        state_d     = DX_FULL;
                        main_load_s = 1'b1;
                        main_d      = skid_q;
                    end else begin
                        state_d = DX_SKID;
                    end
                end
                default: begin
                    state_d = DX_EMPTY;
                end
            endcase
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DX_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    dx_skid_entry #(.WIDTH(PW)) u_main (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (main_load_s),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;

            dx_skid_entry #(.WIDTH(PW)) u_skid (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .load_i (skid_load_s),
                .d_i    (in_payload_s),
                .q_o    (skid_q)
            );

            // Registered ready: low exactly while the skid entry is occupied.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != DX_SKID);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_skid_load;

            assign unused_skid_load = skid_load_s;
            assign skid_q           = '0;
            assign in_ready         = !out_valid || out_ready;
        end
    endgenerate

    // Saturating count of blocked offers; flush deliberately has no effect.
    always_comb begin
        if (in_valid && !in_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid   = (state_q != DX_EMPTY);
    assign {out_ctrl, out_imm, out_rd1, out_rd0, out_pc} = main_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_dx_pipeline_stage.sv
// Directed bench: three stage instances (skid, no-skid, 4-bit counter) share one stimulus.
module tb_dx_pipeline_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_rd0, in_rd1, in_imm;
    logic [15:0] in_ctrl;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [31:0] a_pc, a_rd0, a_rd1, a_imm, b_pc, b_rd0, b_rd1, b_imm, c_pc, c_rd0, c_rd1, c_imm;
    logic [15:0] a_ctrl, b_ctrl, c_ctrl, a_stall, b_stall;
    logic [3:0]  c_stall;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dx_pipeline_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID_EN(1'b1), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_rd0(in_rd0), .in_rd1(in_rd1), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc), .out_rd0(a_rd0),
        .out_rd1(a_rd1), .out_imm(a_imm), .out_ctrl(a_ctrl), .stall_count(a_stall));

    dx_pipeline_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID_EN(1'b0), .CNT_WIDTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_rd0(in_rd0), .in_rd1(in_rd1), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc), .out_rd0(b_rd0),
        .out_rd1(b_rd1), .out_imm(b_imm), .out_ctrl(b_ctrl), .stall_count(b_stall));

    dx_pipeline_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .SKID_EN(1'b1), .CNT_WIDTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_pc(in_pc), .in_rd0(in_rd0), .in_rd1(in_rd1), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_pc(c_pc), .out_rd0(c_rd0),
        .out_rd1(c_rd1), .out_imm(c_imm), .out_ctrl(c_ctrl), .stall_count(c_stall));

    function automatic logic [31:0] f_rd0(input logic [31:0] pc);
        return pc ^ 32'h1111_0000;
    endfunction
    function automatic logic [31:0] f_rd1(input logic [31:0] pc);
        return pc ^ 32'h2222_0000;
    endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] pc);
        return pc + 32'h0000_0100;
    endfunction
    function automatic logic [15:0] f_ctrl(input logic [31:0] pc);
        return pc[15:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_rd0   = f_rd0(pc);
        in_rd1   = f_rd1(pc);
        in_imm   = f_imm(pc);
        in_ctrl  = f_ctrl(pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'd0; in_rd0 = 32'd0; in_rd1 = 32'd0; in_imm = 32'd0; in_ctrl = 16'd0;
        #1;
        chk("rst_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_a_pc", {32'd0, a_pc}, 64'd0);
        chk("rst_a_stall", {48'd0, a_stall}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_a_ready", {63'd0, a_in_ready}, 64'd1);
        chk("post_rst_b_ready", {63'd0, b_in_ready}, 64'd1);

        // Stream four bundles at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'(4 * i));
            tick();
            chk("stream_a_valid", {63'd0, a_out_valid}, 64'd1);
            chk("stream_a_pc", {32'd0, a_pc}, {32'd0, 32'(4 * i)});
            chk("stream_b_pc", {32'd0, b_pc}, {32'd0, 32'(4 * i)});
        end
        chk("stream_a_rd0", {32'd0, a_rd0}, {32'd0, f_rd0(32'h0000_000C)});
        chk("stream_a_rd1", {32'd0, a_rd1}, {32'd0, f_rd1(32'h0000_000C)});
        chk("stream_a_imm", {32'd0, a_imm}, {32'd0, f_imm(32'h0000_000C)});
        chk("stream_a_ctrl", {48'd0, a_ctrl}, {48'd0, f_ctrl(32'h0000_000C)});
        in_valid = 1'b0;
        tick();
        chk("drain_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("stream_a_stall", {48'd0, a_stall}, 64'd0);
        chk("stream_b_stall", {48'd0, b_stall}, 64'd0);

        // Back-pressure: skid takes two, no-skid takes one.
        out_ready = 1'b0;
        offer(32'h0000_0010);
        tick();
        chk("bp1_a_pc", {32'd0, a_pc}, 64'h10);
        chk("bp1_b_pc", {32'd0, b_pc}, 64'h10);
        chk("bp1_a_ready", {63'd0, a_in_ready}, 64'd1);
        chk("bp1_b_ready", {63'd0, b_in_ready}, 64'd0);
        offer(32'h0000_0014);
        tick();
        chk("bp2_a_pc_held", {32'd0, a_pc}, 64'h10);
        chk("bp2_a_ready", {63'd0, a_in_ready}, 64'd0);
        chk("bp2_a_stall", {48'd0, a_stall}, 64'd0);
        chk("bp2_b_stall", {48'd0, b_stall}, 64'd1);
        tick();
        chk("bp3_a_stall", {48'd0, a_stall}, 64'd1);
        chk("bp3_b_stall", {48'd0, b_stall}, 64'd2);
        chk("bp3_b_pc_held", {32'd0, b_pc}, 64'h10);
        out_ready = 1'b1;
        #1;
        chk("rel_b_ready_comb", {63'd0, b_in_ready}, 64'd1);
        chk("rel_a_ready_reg", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk("rel_a_pc", {32'd0, a_pc}, 64'h14);
        chk("rel_a_rd1", {32'd0, a_rd1}, {32'd0, f_rd1(32'h0000_0014)});
        chk("rel_a_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rel_a_stall", {48'd0, a_stall}, 64'd2);
        chk("rel_b_pc", {32'd0, b_pc}, 64'h14);
        chk("rel_b_stall", {48'd0, b_stall}, 64'd2);
        in_valid = 1'b0;
        tick();
        chk("rel_drain_a_valid", {63'd0, a_out_valid}, 64'd0);

        // Flush while the skid entry is occupied.
        out_ready = 1'b0;
        offer(32'h0000_0030);
        tick();
        offer(32'h0000_0034);
        tick();
        offer(32'h0000_0020);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("flush_a_ready", {63'd0, a_in_ready}, 64'd1);
        chk("flush_b_valid", {63'd0, b_out_valid}, 64'd0);
        chk("flush_a_pc_kept", {32'd0, a_pc}, 64'h30);
        chk("flush_a_stall", {48'd0, a_stall}, 64'd3);
        chk("flush_b_stall", {48'd0, b_stall}, 64'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_no_emit_a", {63'd0, a_out_valid}, 64'd0);

        // Long stall: 4-bit counter saturates, 16-bit keeps counting.
        out_ready = 1'b0;
        offer(32'h0000_0050);
        tick();
        offer(32'h0000_0054);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("sat_c_stall", {60'd0, c_stall}, 64'hF);
        chk("sat_a_stall", {48'd0, a_stall}, 64'h17);
        chk("sat_b_stall", {48'd0, b_stall}, 64'h19);
        chk("sat_a_pc_held", {32'd0, a_pc}, 64'h50);
        chk("sat_a_imm_held", {32'd0, a_imm}, {32'd0, f_imm(32'h0000_0050)});

        // Asynchronous reset in the middle of the stall.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("arst_a_pc", {32'd0, a_pc}, 64'd0);
        chk("arst_a_ctrl", {48'd0, a_ctrl}, 64'd0);
        chk("arst_a_stall", {48'd0, a_stall}, 64'd0);
        chk("arst_c_stall", {60'd0, c_stall}, 64'd0);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_post_a_valid", {63'd0, a_out_valid}, 64'd0);
        chk("arst_post_a_ready", {63'd0, a_in_ready}, 64'd1);
        offer(32'h0000_0040);
        tick();
        chk("arst_new_a_pc", {32'd0, a_pc}, 64'h40);
        chk("arst_new_a_valid", {63'd0, a_out_valid}, 64'd1);
        chk("arst_new_b_pc", {32'd0, b_pc}, 64'h40);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dx_pipeline_stage.md
# dx_pipeline_stage

Parametrised decode-to-execute pipeline stage that carries PC, two register-read operands, immediate and a control bundle from decode into execute. Adds a valid/ready handshake, back-pressure with an optional skid entry, a synchronous flush for branch redirects, and a saturating stall counter. It replaces the free-running D/X register between the register file/decoder and the ALU stage.

## Interface
- DATA_WIDTH, 32, width of pc, rd0, rd1 and imm fields
- CTRL_WIDTH, 16, width of decoded control bundle
- SKID_EN, 1, 1 = two-entry stage with registered in_ready; 0 = single entry with combinational in_ready
- CNT_WIDTH, 16, width of stall counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  decode offers a bundle
- in_ready  out  1  stage accepts the bundle this cycle
- in_pc, in_rd0, in_rd1, in_imm  in  DATA_WIDTH each  payload fields
- in_ctrl  in  CTRL_WIDTH  control bundle
- out_valid  out  1  execute-side bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc, out_rd0, out_rd1, out_imm  out  DATA_WIDTH each  registered payload
- out_ctrl  out  CTRL_WIDTH  registered control
- stall_count  out  CNT_WIDTH  saturating count of cycles with in_valid=1 and in_ready=0

## Operation
- Accept: in_valid && in_ready. Fire: out_valid && out_ready.
- States: EMPTY (no entry), FULL (main entry valid), SKID (main + skid valid; only when SKID_EN=1).
- EMPTY: accept -> FULL, main <= input.
- FULL: fire and accept -> FULL, main <= input; fire only -> EMPTY; accept only -> SKID, skid <= input; neither -> FULL, main held.
- SKID: no accept possible; fire -> FULL, main <= skid; else hold.
- in_ready: SKID_EN=1: registered, equals (state != SKID). SKID_EN=0: in_ready = !out_valid || out_ready; SKID never entered.
- out_valid = (state != EMPTY); out_* always drive main entry.
- flush: next state EMPTY regardless of accept/fire in the same cycle; input offered in the flush cycle is dropped. Payload registers are not cleared by flush.
- Payload is held bit-exact while out_valid && !out_ready.
- stall_count increments by 1 each cycle in_valid && !in_ready, saturates at all-ones, unaffected by flush; cleared only by reset.

## Timing
- Reset (rst_n=0, asynchronous): state EMPTY, out_valid=0, all out_* payload=0, stall_count=0; in_ready=1 from first cycle after reset in both modes (SKID_EN=0: combinationally since out_valid=0).
- Latency: accept at edge N -> out_valid=1 with that payload after edge N.
- Throughput: one bundle per cycle when out_ready held high.
- SKID_EN=1: in_ready falls one cycle after the entry into SKID and rises the cycle after the fire that leaves SKID; no combinational path out_ready -> in_ready.
- Reset asserted mid-transfer discards both entries; no partial bundle survives.
- flush has priority over every other transition.

## Structure
- Shared package dx_pkg: state enum (DX_EMPTY, DX_FULL, DX_SKID), payload struct/packed width constant (4*DATA_WIDTH + CTRL_WIDTH), field order {ctrl, imm, rd1, rd0, pc}.
- Payload packed into one vector internally; one sub-module dx_skid_entry (width-parametrised load/hold register with async reset) instantiated for main and, under generate SKID_EN, for skid.
- Stall counter inline.

## Test plan
- Reset then stream 4 bundles (pc=0x0,0x4,0x8,0xC) with out_ready=1 -> out_pc 0x0..0xC on consecutive cycles, one cycle latency, stall_count=0.
- SKID_EN=1: hold out_ready=0, offer pc=0x10 then 0x14 -> both accepted, in_ready=0 on third cycle, stall_count increments each blocked cycle; release out_ready -> 0x10 then 0x14 emitted in order.
- SKID_EN=0 same stimulus -> only 0x10 accepted, in_ready tracks out_ready combinationally, 0x14 accepted on the release cycle.
- flush while in SKID with in_valid=1 (pc=0x20) -> out_valid=0 next cycle, 0x20 not emitted, in_ready=1.
- stall_count with CNT_WIDTH=4, blocked 20 cycles -> stops at 0xF.
- Assert rst_n mid-stall -> out_valid and payload 0 immediately, state EMPTY after release.
